// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory controller.
//   - state_e      : controller mode (boot load, CPU run, one-cycle drain)
//   - DEF_ADDR_W   : default word-index width (memory depth = 2**DEF_ADDR_W words)
//   - DEF_NOP_INST : instruction returned for misaligned fetches
package imem_pkg;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/imem_ctrl.sv
// imem_ctrl: owns the single-port synchronous instruction memory and shares it
// between a boot-load stream and the CPU fetch path.
//
// Ports
//   i_clk, i_rst             : clock (rising edge), synchronous active-high reset
//   i_boot_valid/data/last   : boot word stream; o_boot_ready accepts a word
//   i_reload                 : pulse, return to boot mode (through a drain cycle)
//   o_cpu_halt               : CPU must stall (high whenever not in run mode)
//   i_fetch_req, i_fetch_addr: CPU fetch request with byte address
//   o_fetch_gnt              : fetch accepted this cycle (combinational)
//   o_fetch_valid/inst       : fetch response, one cycle after the grant
//   o_fetch_misalign         : response belongs to a misaligned fetch (NOP returned)
//   o_mem_en/we/idx/wdata    : memory port; i_mem_rdata valid one cycle after a read
//   o_load_count             : words written in the current boot (saturating)
//   o_load_err               : sticky, boot stream overflowed the memory depth
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_boot_valid,
    input  logic [31:0]       i_boot_data,
    input  logic              i_boot_last,
    output logic              o_boot_ready,

    input  logic              i_reload,
    output logic              o_cpu_halt,

    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_valid,
    output logic [31:0]       o_fetch_inst,
    output logic              o_fetch_misalign,

    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_idx,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,

    output logic [ADDR_W:0]   o_load_count,
    output logic              o_load_err
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e             r_state;
    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  r_load_ptr;
    logic [ADDR_W-1:0]  w_load_ptr_nxt;
    logic [ADDR_W:0]    r_load_count;
    logic [ADDR_W:0]    w_load_count_nxt;
    logic               r_load_err;
    logic               w_load_err_nxt;

    // Response pipeline: one stage matching the memory read latency.
    logic               r_rsp_valid;
    logic               r_rsp_misalign;
    logic [31:0]        r_inst_hold;

    logic               w_boot_ready;
    logic               w_cpu_halt;
    logic               w_gnt;
    logic               w_mem_en;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_idx;
    logic [31:0]        w_rsp_inst;
    logic               w_misalign_req;

    // Upper fetch address bits are deliberately ignored (addresses alias).
    logic               w_unused_addr;
    assign w_unused_addr  = ^i_fetch_addr[31:ADDR_W+2];

    assign w_misalign_req = |i_fetch_addr[1:0];

    // ---------------------------------------------------------------------
    // Next-state and memory-port decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_ptr_nxt   = r_load_ptr;
        w_load_count_nxt = r_load_count;
        w_load_err_nxt   = r_load_err;
        w_boot_ready     = 1'b0;
        w_cpu_halt       = 1'b1;
        w_gnt            = 1'b0;
        w_mem_en         = 1'b0;
        w_mem_we         = 1'b0;
        w_mem_idx        = r_load_ptr;

        unique case (r_state)
            StBoot: begin
                // Held off during reset so no stray write reaches the memory.
                w_boot_ready = !i_rst;
                if (w_boot_ready && i_boot_valid) begin
                    w_mem_en       = 1'b1;
                    w_mem_we       = 1'b1;
                    w_load_ptr_nxt = r_load_ptr + 1'b1;
                    if (r_load_count != CNT_MAX) begin
                        w_load_count_nxt = r_load_count + 1'b1;
                    end
                    if (i_boot_last) begin
                        w_state_nxt = StRun;
                    end else if (r_load_ptr == PTR_MAX) begin
                        // Stream longer than the memory: pointer wraps, flag it.
                        w_load_err_nxt = 1'b1;
                    end
                end
            end

            StRun: begin
                w_cpu_halt = 1'b0;
                // Reload wins over a simultaneous fetch.
                w_gnt      = i_fetch_req && !i_reload && !i_rst;
                if (w_gnt) begin
                    w_mem_en  = 1'b1;
                    w_mem_idx = i_fetch_addr[ADDR_W+1:2];
                end
                if (i_reload) begin
                    w_state_nxt = StDrain;
                end
            end

            StDrain: begin
                // The last RUN grant's response is delivered during this cycle.
                w_load_ptr_nxt   = '0;
                w_load_count_nxt = '0;
                w_load_err_nxt   = 1'b0;
                w_state_nxt      = StBoot;
            end

            default: begin
                w_state_nxt = StBoot;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StBoot;
            r_load_ptr     <= '0;
            r_load_count   <= '0;
            r_load_err     <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_misalign <= 1'b0;
            r_inst_hold    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_load_ptr     <= w_load_ptr_nxt;
            r_load_count   <= w_load_count_nxt;
            r_load_err     <= w_load_err_nxt;
            r_rsp_valid    <= w_gnt;
            r_rsp_misalign <= w_gnt && w_misalign_req;
            if (r_rsp_valid) begin
                r_inst_hold <= w_rsp_inst;
            end
        end
    end

    // Read data is only valid in the response cycle; afterwards the captured
    // copy keeps the instruction output stable.
    assign w_rsp_inst       = r_rsp_misalign ? NOP_INST : i_mem_rdata;

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_boot_ready     = w_boot_ready;
    assign o_cpu_halt       = w_cpu_halt;
    assign o_fetch_gnt      = w_gnt;
    assign o_fetch_valid    = r_rsp_valid;
    assign o_fetch_inst     = r_rsp_valid ? w_rsp_inst : r_inst_hold;
    assign o_fetch_misalign = r_rsp_valid && r_rsp_misalign;
    assign o_mem_en         = w_mem_en;
    assign o_mem_we         = w_mem_we;
    assign o_mem_idx        = w_mem_idx;
    assign o_mem_wdata      = i_boot_data;
    assign o_load_count     = r_load_count;
    assign o_load_err       = r_load_err;

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Controller that owns the single-port synchronous instruction memory, which it shares between a boot-load stream and the CPU fetch path. After reset it holds the CPU halted and writes a stream of 32-bit words into the memory from word 0 upward. It then releases the CPU and serves byte-addressed fetches with a fixed one-cycle read latency. A reload request returns it to boot mode without losing an in-flight fetch.

## Interface
- `ADDR_W`, 12, word-index width; memory depth = 2^ADDR_W words.
- `NOP_INST`, 32'h0000_0000, instruction returned for misaligned fetches.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `boot_valid` in 1: boot word present.
- `boot_data` in 32: boot word.
- `boot_last` in 1: qualifies the final boot word.
- `boot_ready` out 1: controller accepts a boot word this cycle.
- `reload` in 1: pulse requesting a return to boot mode.
- `cpu_halt` out 1: CPU must stall; high whenever the controller is not in RUN.
- `fetch_req` in 1: CPU fetch request.
- `fetch_addr` in 32: byte address of the fetch.
- `fetch_gnt` out 1: fetch accepted this cycle (combinational).
- `fetch_valid` out 1: `fetch_inst` is valid this cycle.
- `fetch_inst` out 32: fetched instruction.
- `fetch_misalign` out 1: pulses with `fetch_valid` when `fetch_addr[1:0]` was nonzero.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_idx` out ADDR_W: memory word index.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: read data, valid one cycle after `mem_en && !mem_we`.
- `load_count` out ADDR_W+1: number of words written in the current boot.
- `load_err` out 1: sticky flag; boot stream overflowed the memory depth.

## Operation
- The FSM has three states: BOOT, RUN, DRAIN.
- **BOOT**
  - `boot_ready`=1 and `cpu_halt`=1.
  - A handshake (`boot_valid && boot_ready`) writes `boot_data` to `mem_idx`=load pointer, with `mem_en`=`mem_we`=1.
  - The same handshake increments both the load pointer and `load_count`.
  - A handshake with `boot_last`=1 moves to RUN.
  - Load pointer at 2^ADDR_W−1 and a non-last handshake: the word is written, the pointer wraps to 0, `load_err` is set, and the FSM stays in BOOT.
  - `load_count` saturates at 2^ADDR_W.
  - `fetch_req` is ignored and `reload` is ignored.
- **RUN**
  - `boot_ready`=0 and `cpu_halt`=0.
  - `fetch_gnt` = `fetch_req && !reload`.
  - A grant drives a read: `mem_en`=1, `mem_we`=0, `mem_idx`=`fetch_addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias.
  - The response comes one cycle later: `fetch_valid`=1 and `fetch_inst`=`mem_rdata`.
  - If the granted address had `[1:0]`≠0, the response instead carries `fetch_inst`=`NOP_INST` and `fetch_misalign`=1. The memory read is still issued.
  - `reload`=1 moves to DRAIN, and `reload` has priority over a simultaneous `fetch_req`.
- **DRAIN**
  - One cycle long; `cpu_halt`=1 and no grants are issued.
  - The response to a fetch granted in the last RUN cycle is delivered here.
  - On exit the load pointer and `load_count` clear to 0, `load_err` clears, and the FSM moves to BOOT.
- `fetch_inst` holds its last value when `fetch_valid`=0.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - state BOOT, so `boot_ready`=1 and `cpu_halt`=1.
  - `fetch_gnt`=0, `fetch_valid`=0, `fetch_inst`=0, `fetch_misalign`=0.
  - `mem_en`=0, `mem_we`=0.
  - `load_count`=0, `load_err`=0.
- While `rst` is high, `boot_ready`=0 and `mem_en`=0.
- `rst` mid-operation: any outstanding response is dropped, so there is no `fetch_valid` after reset, and a partial boot restarts at word 0.
- Boot throughput is one word per cycle.
- The first RUN cycle is the cycle after the `boot_last` handshake.
- Fetch latency: grant in cycle T gives `fetch_valid` in T+1. Back-to-back grants every cycle are allowed.
- Write-then-read of the same word cannot occur, because the modes are exclusive.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum (BOOT, RUN, DRAIN);
  - `NOP_INST`;
  - the default `ADDR_W`.
- No sub-module is required; the memory array is instantiated outside this block.

## Test plan
- Boot 4 words 0x11,0x22,0x33,0x44 with last on the 4th → four writes at idx 0..3, `load_count`=4, RUN on the next cycle, `cpu_halt` falls.
- RUN: fetches to 0x0,0x4,0x8 on consecutive cycles → `fetch_valid` on the 3 following cycles carrying 0x11,0x22,0x33.
- Fetch 0x6 → `mem_idx`=1, response `fetch_inst`=0 with `fetch_misalign`=1; fetch 0x4004 (ADDR_W=12) → aliases to idx 1, returns 0x22.
- `reload` and `fetch_req` high in the same cycle, right after an earlier grant → no new grant, the prior response arrives in DRAIN, then BOOT with `load_count`=0.
- Boot with ADDR_W=2, 5 words and no last → idx 0,1,2,3,0 written, `load_err`=1, still in BOOT.
- Assert `rst` mid-boot and one cycle after a grant → no `fetch_valid`, all outputs at reset values, next boot writes idx 0.
